// File: rtl/imm_encoder_loader_if.sv
// imm_encoder_loader_if: field stream, session control and instruction-memory write bus of the encoder/loader
interface imm_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0] count;
  logic in_valid;
  logic in_ready;
  logic [1:0] fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [63:0] imm;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy;
  logic done;
  logic err;
  logic [7:0] err_count;
  modport master (
    output start, base_addr, count, in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
  );
  modport slave (
    input start, base_addr, count, in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
  );
endinterface

// File: rtl/imm_encoder_loader.sv
// imm_encoder_loader: range-checks decoded instruction fields and writes packed RISC-V words to consecutive instruction-memory addresses
module imm_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic reset,
  imm_encoder_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [7:0] rem_q, rem_d, errc_q, errc_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic we_q, we_d, err_q, err_d;
  logic run, xfer, i_ok, b_ok, legal;
  logic [63:0] imm;
  assign imm = bus.imm;
  assign i_ok = &imm[63:11] | ~|imm[63:11];
  assign b_ok = (&imm[63:12] | ~|imm[63:12]) & ~imm[0];
  assign legal = bus.fmt == 2'd3 | (bus.fmt == 2'd2 ? b_ok : i_ok);
  assign word = bus.fmt == 2'd0 ? {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode}
              : bus.fmt == 2'd1 ? {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode}
              : bus.fmt == 2'd2 ? {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], bus.opcode}
              : {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
  assign run = state_q == RUN;
  assign xfer = bus.in_valid & run;
  assign bus.in_ready = run;
  assign bus.busy = run;
  assign bus.done = state_q == DONE;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err = err_q;
  assign bus.err_count = errc_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    errc_d = errc_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d = bus.count != 8'd0 ? RUN : DONE;
      if (bus.count != 8'd0) begin
        ptr_d = bus.base_addr;
        rem_d = bus.count;
        errc_d = 8'd0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (xfer) begin
      rem_d = rem_q - 8'd1;
      state_d = rem_q == 8'd1 ? DONE : RUN;
      we_d = legal;
      err_d = ~legal;
      addr_d = legal ? ptr_q : addr_q;
      wdata_d = legal ? word : wdata_q;
      ptr_d = legal ? ptr_q + ADDR_W'(4) : ptr_q;
      errc_d = legal || errc_q == 8'hFF ? errc_q : errc_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rem_q <= '0;
      errc_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      errc_q <= errc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_imm_encoder_loader.sv
// tb_imm_encoder_loader: directed vector table, corner sequences and randomized sessions against a reference model
module tb_imm_encoder_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  imm_encoder_loader_if #(.ADDR_W(8)) bus ();
  imm_encoder_loader #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic new_s;
    logic [7:0] base;
    logic [7:0] cnt;
    logic [1:0] fmt;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [63:0] imm;
    logic we;
    logic er;
    logic dn;
    logic [7:0] addr;
    logic [31:0] wd;
    logic [7:0] ec;
  } vec_t;
  vec_t vt[6];
  longint bnd[9] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 4095};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_session(input logic [7:0] base, input logic [7:0] cnt);
    tick();
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.count = cnt;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic drive(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
    bus.fmt = fmt;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rd = rd;
    bus.rs1 = rs1;
    bus.rs2 = rs2;
    bus.imm = imm;
    bus.in_valid = 1'b1;
  endtask
  task automatic xfer(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
    chk("in_ready_before_xfer", bus.in_ready, 1);
    drive(fmt, op, f3, f7, rd, rs1, rs2, imm);
    tick();
    bus.in_valid = 1'b0;
  endtask
  function automatic bit ref_legal(input logic [1:0] fmt, input logic [63:0] imm);
    longint s = longint'(imm);
    if (fmt == 2'd3) return 1'b1;
    if (fmt == 2'd2) return s >= -4096 && s <= 4095 && (s % 2) == 0;
    return s >= -2048 && s <= 2047;
  endfunction
  function automatic logic [31:0] ref_enc(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [63:0] u);
    logic [63:0] w = 64'(op) + (64'(f3) << 12) + (64'(rs1) << 15);
    case (fmt)
      2'd0: w += (64'(rd) << 7) + ((u & 64'hFFF) << 20);
      2'd1: w += ((u & 64'd31) << 7) + (64'(rs2) << 20) + (((u >> 5) & 64'd127) << 25);
      2'd2: w += (((u >> 11) & 64'd1) << 7) + (((u >> 1) & 64'd15) << 8) + (64'(rs2) << 20)
               + (((u >> 5) & 64'd63) << 25) + (((u >> 12) & 64'd1) << 31);
      default: w += (64'(rd) << 7) + (64'(rs2) << 20) + (64'(f7) << 25);
    endcase
    return w[31:0];
  endfunction
  function automatic logic [63:0] immgen(input logic [1:0] fmt, input logic [31:0] w);
    if (fmt == 2'd0) return {{52{w[31]}}, w[31:20]};
    if (fmt == 2'd1) return {{52{w[31]}}, w[31:25], w[11:7]};
    return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  initial begin
    vt[0] = '{1'b1, 8'h40, 8'd1, 2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF,
              1'b1, 1'b0, 1'b1, 8'h40, 32'hFFF00093, 8'd0};
    vt[1] = '{1'b1, 8'h00, 8'd2, 2'd1, 7'h23, 3'd3, 7'd0, 5'd0, 5'd0, 5'd2, 64'd104,
              1'b1, 1'b0, 1'b0, 8'h00, 32'h06203423, 8'd0};
    vt[2] = '{1'b0, 8'h00, 8'd0, 2'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8,
              1'b1, 1'b0, 1'b1, 8'h04, 32'h00208463, 8'd0};
    vt[3] = '{1'b1, 8'h80, 8'd3, 2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd2048,
              1'b0, 1'b1, 1'b0, 8'h04, 32'h00208463, 8'd1};
    vt[4] = '{1'b0, 8'h00, 8'd0, 2'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd7,
              1'b0, 1'b1, 1'b0, 8'h04, 32'h00208463, 8'd2};
    vt[5] = '{1'b0, 8'h00, 8'd0, 2'd3, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0,
              1'b1, 1'b0, 1'b1, 8'h80, 32'h002081B3, 8'd2};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    drive(2'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_err_count", bus.err_count, 0);
    for (int i = 0; i < 6; i++) begin
      if (vt[i].new_s) begin
        begin_session(vt[i].base, vt[i].cnt);
        chk("vec_busy", bus.busy, 1);
      end
      xfer(vt[i].fmt, vt[i].op, vt[i].f3, vt[i].f7, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      chk($sformatf("vec%0d_we", i), bus.mem_we, vt[i].we);
      chk($sformatf("vec%0d_err", i), bus.err, vt[i].er);
      chk($sformatf("vec%0d_done", i), bus.done, vt[i].dn);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].addr);
      chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].wd);
      chk($sformatf("vec%0d_errc", i), bus.err_count, vt[i].ec);
      if (i == 0) begin
        tick();
        chk("vec0_busy_after", bus.busy, 0);
        chk("vec0_done_once", bus.done, 0);
        chk("vec0_we_once", bus.mem_we, 0);
      end
    end
    begin_session(8'hFC, 8'd2);
    xfer(2'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 64'd12);
    chk("wrap_addr0", bus.mem_addr, 8'hFC);
    chk("wrap_we0", bus.mem_we, 1);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_we", bus.mem_we, 0);
      chk("gap_in_ready", bus.in_ready, 1);
    end
    xfer(2'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 64'd13);
    chk("wrap_addr1", bus.mem_addr, 8'h00);
    chk("wrap_done", bus.done, 1);
    tick();
    chk("wrap_in_ready_end", bus.in_ready, 0);
    bus.start = 1'b1;
    bus.count = 8'd0;
    bus.base_addr = 8'h99;
    tick();
    bus.start = 1'b0;
    chk("cnt0_done", bus.done, 1);
    chk("cnt0_we", bus.mem_we, 0);
    chk("cnt0_busy", bus.busy, 0);
    tick();
    chk("cnt0_done_once", bus.done, 0);
    chk("cnt0_we_after", bus.mem_we, 0);
    begin_session(8'h10, 8'd2);
    xfer(2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 64'd5);
    chk("bstart_addr0", bus.mem_addr, 8'h10);
    bus.start = 1'b1;
    bus.base_addr = 8'h50;
    bus.count = 8'd5;
    tick();
    bus.start = 1'b0;
    chk("bstart_busy", bus.busy, 1);
    chk("bstart_we", bus.mem_we, 0);
    xfer(2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 64'd6);
    chk("bstart_addr1", bus.mem_addr, 8'h14);
    chk("bstart_done", bus.done, 1);
    begin_session(8'h20, 8'd3);
    xfer(2'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, 64'd2049);
    chk("rmid_err_count", bus.err_count, 1);
    drive(2'd0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("rmid_we", bus.mem_we, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_in_ready", bus.in_ready, 0);
    chk("rmid_err_count0", bus.err_count, 0);
    begin_session(8'h30, 8'd1);
    xfer(2'd0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 64'd1);
    chk("rmid_new_addr", bus.mem_addr, 8'h30);
    chk("rmid_new_we", bus.mem_we, 1);
    chk("rmid_new_done", bus.done, 1);
    begin
      logic [7:0] ptr, ecnt, e_addr;
      logic [31:0] e_wd;
      logic [63:0] imm;
      logic [1:0] fmt;
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [4:0] rd, rs1, rs2;
      int cnt;
      bit lg;
      e_addr = bus.mem_addr;
      e_wd = bus.mem_wdata;
      for (int s = 0; s < 8; s++) begin
        ptr = 8'($urandom_range(0, 255));
        cnt = $urandom_range(1, 6);
        ecnt = 8'd0;
        begin_session(ptr, 8'(cnt));
        for (int t = 0; t < cnt; t++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            tick();
            chk("rnd_gap_we", bus.mem_we, 0);
            chk("rnd_gap_err", bus.err, 0);
          end
          fmt = 2'($urandom_range(0, 3));
          op = 7'($urandom);
          f3 = 3'($urandom);
          f7 = 7'($urandom);
          rd = 5'($urandom);
          rs1 = 5'($urandom);
          rs2 = 5'($urandom);
          case ($urandom_range(0, 3))
            0: imm = {$urandom, $urandom};
            1: imm = 64'(longint'($urandom_range(0, 8191)) - 64'sd4096);
            2: imm = 64'(bnd[$urandom_range(0, 8)]);
            default: imm = 64'(longint'($urandom_range(0, 2047)) * 2 - 64'sd2048);
          endcase
          lg = ref_legal(fmt, imm);
          if (lg) begin
            e_addr = ptr;
            e_wd = ref_enc(fmt, op, f3, f7, rd, rs1, rs2, imm);
            ptr = ptr + 8'd4;
          end else begin
            ecnt = ecnt + 8'd1;
          end
          xfer(fmt, op, f3, f7, rd, rs1, rs2, imm);
          chk("rnd_we", bus.mem_we, lg);
          chk("rnd_err", bus.err, !lg);
          chk("rnd_addr", bus.mem_addr, e_addr);
          chk("rnd_wdata", bus.mem_wdata, e_wd);
          chk("rnd_err_count", bus.err_count, ecnt);
          chk("rnd_done", bus.done, t == cnt - 1);
          if (lg && fmt != 2'd3) chk("rnd_roundtrip", immgen(fmt, bus.mem_wdata), imm);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
